// File: rtl/gate_range_pkg.sv
// Shared types and helpers for the gate/range measurement sequencer.
package gate_range_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GATE,
        EVAL,
        RESTART,
        PUBLISH
    } state_t;

    localparam logic [3:0] RANGE_MAX = 4'd9;

    function automatic logic [9:0] idx_to_onehot(input logic [3:0] idx);
        logic [9:0] oh;
        oh = '0;
        if (idx <= RANGE_MAX) begin
            oh = 10'(1) << idx;
        end
        return oh;
    endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// one-cycle rising-edge pulse (three cycles from input edge to pulse visible + 1 to use).
module edge_sync_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    // [0] and [1] are the synchronizer, [2] is the previous synchronized value.
    logic [2:0] sync_q, sync_d;
    logic       pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[1:0], din};
        pulse_d = sync_q[1] & ~sync_q[2];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/gate_range_ctrl.sv
// Frequency-counter measurement sequencer: gates edge counting between two divider
// toggles and optionally auto-ranges the gate length (macro AUTORANGE_EN).
module gate_range_ctrl #(
    parameter int unsigned      CNT_W     = 24,
    parameter logic [CNT_W-1:0] HI_THRESH = CNT_W'(9_000_000),
    parameter logic [CNT_W-1:0] LO_THRESH = CNT_W'(900_000),
    parameter int unsigned      MAX_RETRY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic [3:0]       range_init,
    input  logic             sig_in,
    input  logic             div_clk,
    output logic [9:0]       div_factor,
    output logic             div_rst_n,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       range_idx,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    import gate_range_pkg::*;

    state_t           state_q, state_d;
    logic [3:0]       cur_idx_q, cur_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             div_clk_q;
    logic [9:0]       div_factor_q, div_factor_d;
    logic             div_rst_n_q, div_rst_n_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       range_idx_q, range_idx_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             tog, edge_pulse;
    logic             step_down, step_up;

    function automatic logic [3:0] clamp_idx(input logic [3:0] idx);
        return (idx > RANGE_MAX) ? RANGE_MAX : idx;
    endfunction

    edge_sync_detect u_sig_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sig_in),
        .pulse (edge_pulse)
    );

    assign tog = div_clk ^ div_clk_q;

`ifdef AUTORANGE_EN
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               may_retry;

    assign may_retry = retry_q < RETRY_W'(MAX_RETRY);
    assign step_down = ((cnt_q >= HI_THRESH) || sat_q) && (cur_idx_q != 4'd0) && may_retry;
    assign step_up   = !step_down && (cnt_q < LO_THRESH) && (cur_idx_q < RANGE_MAX) && may_retry;

    always_comb begin
        retry_d = retry_q;
        if (state_q == EVAL && (step_down || step_up)) begin
            retry_d = retry_q + 1'b1;
        end else if (state_q == PUBLISH || (state_q == IDLE && start)) begin
            retry_d = '0;
        end
    end
`else
    // Keeps the range parameters referenced in fixed-range builds.
    logic unused_range_cfg;
    assign unused_range_cfg = ^{HI_THRESH, LO_THRESH, MAX_RETRY};
    assign step_down = 1'b0;
    assign step_up   = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        div_factor_d = div_factor_q;
        div_rst_n_d  = div_rst_n_q;
        count_d      = count_q;
        range_idx_d  = range_idx_q;
        valid_d      = 1'b0;
        overflow_d   = overflow_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                div_rst_n_d = 1'b0;
                if (start) begin
                    cur_idx_d    = clamp_idx(range_init);
                    div_factor_d = idx_to_onehot(clamp_idx(range_init));
                    busy_d       = 1'b1;
                    state_d      = ARM;
                end
            end
            ARM: begin
                cnt_d       = '0;
                sat_d       = 1'b0;
                div_rst_n_d = 1'b1;
                // A toggle seen while the divider is still held is reset debris.
                if (tog && div_rst_n_q) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                // Saturation flags an edge that could not be counted.
                if (edge_pulse) begin
                    if (&cnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (tog) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                div_rst_n_d = 1'b0;
                if (step_down) begin
                    cur_idx_d = cur_idx_q - 1'b1;
                    state_d   = RESTART;
                end else if (step_up) begin
                    cur_idx_d = cur_idx_q + 1'b1;
                    state_d   = RESTART;
                end else begin
                    count_d     = cnt_q;
                    range_idx_d = cur_idx_q;
                    overflow_d  = sat_q;
                    valid_d     = 1'b1;
                    state_d     = PUBLISH;
                end
            end
            RESTART: begin
                div_rst_n_d  = 1'b0;
                cnt_d        = '0;
                sat_d        = 1'b0;
                div_factor_d = idx_to_onehot(cur_idx_q);
                state_d      = ARM;
            end
            PUBLISH: begin
                div_rst_n_d = 1'b0;
                if (continuous) begin
                    state_d = RESTART;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_idx_q    <= 4'd0;
            sat_q        <= 1'b0;
            div_clk_q    <= 1'b0;
            div_factor_q <= idx_to_onehot(4'd0);
            div_rst_n_q  <= 1'b0;
            count_q      <= '0;
            range_idx_q  <= 4'd0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AUTORANGE_EN
            retry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            sat_q        <= sat_d;
            div_clk_q    <= div_clk;
            div_factor_q <= div_factor_d;
            div_rst_n_q  <= div_rst_n_d;
            count_q      <= count_d;
            range_idx_q  <= range_idx_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
`ifdef AUTORANGE_EN
            retry_q      <= retry_d;
`endif
        end
    end

    // The edge counter is cleared in ARM/RESTART before every gate.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign div_factor = div_factor_q;
    assign div_rst_n  = div_rst_n_q;
    assign count      = count_q;
    assign range_idx  = range_idx_q;
    assign valid      = valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: doc/gate_range_ctrl.md
Name: gate_range_ctrl

Overview:
- Measurement sequencer for the variable-frequency counter.
- Drives the one-hot prescale select and the restart of the frequency divider, then uses two consecutive toggles of the divider output as a gate window.
- Counts rising edges of the measured signal inside that window and auto-ranges the gate length until the count sits inside a target band.
- Publishes the count, the range index and a valid pulse to the display/readout logic.

Parameters:
- CNT_W, 24, width of the edge counter and the result.
- HI_THRESH, 24'd9_000_000: count >= this selects a shorter gate.
- LO_THRESH, 24'd900_000: count < this selects a longer gate.
- MAX_RETRY, 4: maximum number of re-range passes before the result is published anyway.

Ports:
- clk  input  1  system clock; the divider runs on the same clock.
- reset  input  1  synchronous, active-low.
- start  input  1  one-cycle pulse that begins a measurement; ignored while busy.
- continuous  input  1  1 = restart automatically after each publish.
- range_init  input  4  starting range index, 0..9; values above 9 clamp to 9.
- sig_in  input  1  measured signal, asynchronous.
- div_clk  input  1  divider output, same clock domain.
- div_factor  output  10  one-hot prescale select, bit k = range index k.
- div_rst_n  output  1  active-low divider restart.
- count  output  CNT_W  last published edge count.
- range_idx  output  4  range index used for the published count.
- valid  output  1  one-cycle pulse when count/range_idx update.
- overflow  output  1  published count saturated.
- busy  output  1  high from start until publish.

Behaviour:
- Reset (reset=0 at a clk edge) is synchronous. Every output takes its reset value in the same edge:
  - state=IDLE
  - div_factor=10'b1 (index 0), div_rst_n=0
  - count=0, range_idx=0, valid=0, overflow=0, busy=0
  - retry counter=0
- sig_in passes through a 2-FF synchronizer, then a rising-edge detector. Edge-to-count latency is 3 cycles.
- div_clk toggle detect: tog = div_clk XOR div_clk_q, where div_clk_q is a 1-cycle register.
- State machine:
  - IDLE: div_rst_n=0. On start, load cur_idx=min(range_init,9) and go to ARM. busy=1 from the next cycle.
  - ARM: div_rst_n=1, div_factor=1<<cur_idx, edge counter cleared. On tog, go to GATE.
  - GATE: counter increments on each synced rising edge and saturates at all-ones, setting an internal sat flag. On the next tog, go to EVAL. An edge coinciding with the closing tog is counted.
  - EVAL (1 cycle):
    - If (cnt>=HI_THRESH or sat) and cur_idx>0 and retry<MAX_RETRY: cur_idx-=1, retry+=1, go to RESTART.
    - Else if cnt<LO_THRESH and cur_idx<9 and retry<MAX_RETRY: cur_idx+=1, retry+=1, go to RESTART.
    - Else go to PUBLISH.
  - RESTART (1 cycle): div_rst_n=0, counter cleared, then ARM.
  - PUBLISH (1 cycle):
    - count<=cnt, range_idx<=cur_idx, overflow<=sat, valid=1, retry<=0.
    - If continuous, go to RESTART keeping cur_idx (auto-tracking); otherwise go to IDLE and busy<=0.
- div_factor changes only in IDLE/RESTART, while div_rst_n=0. It is never changed mid-gate.
- start during busy is ignored. Deasserting continuous mid-measurement takes effect at the next PUBLISH.
- count/range_idx/overflow hold between valid pulses.
- Reset mid-gate aborts the measurement with no valid pulse.

Optional Feature:
- Macro AUTORANGE_EN.
- Defined: EVAL performs re-ranging as above.
- Undefined: EVAL always goes to PUBLISH, cur_idx stays range_init, and the retry logic and thresholds are not synthesized.

Decomposition:
- Package gate_range_pkg holds:
  - state enum (IDLE, ARM, GATE, EVAL, RESTART, PUBLISH)
  - RANGE_MAX=9
  - function idx_to_onehot(4-bit)->10-bit
- One natural sub-module: edge_sync_detect (2-FF synchronizer plus rising-edge pulse). It is reusable for other asynchronous inputs.

Test Plan:
- Bench model: real divider behaviour, where a toggle occurs after (1<<(18+k))+1 cycles from restart.
- Reset: assert reset=0 mid-GATE -> next cycle all outputs at reset values, div_rst_n=0, no valid.
- Fixed range (AUTORANGE_EN undefined): range_init=0, sig_in period 64 clk -> one valid, count=4096±1, range_idx=0, overflow=0.
- Auto-range up (AUTORANGE_EN defined): LO_THRESH=5000, range_init=0, sig_in period 64 -> first gate 4096 < 5000, re-range to idx 1 -> valid with count=8192±1, range_idx=1.
- Auto-range down and saturation: CNT_W=12, HI_THRESH=4000, sig_in period 4 at idx 1 -> saturates, steps to idx 0, still saturated -> valid with count=4095, overflow=1, range_idx=0.
- Retry limit: MAX_RETRY=2, range_init=0, LO_THRESH above every reachable count -> exactly 2 re-ranges, valid at range_idx=2.
- Continuous mode: continuous=1, one start -> valid pulses every gate+restart interval; start pulses while busy have no effect; clearing continuous -> busy falls after the next valid.
